// File: rtl/astra_pifo_array.sv
// Purpose: sorted push-in/first-out array; lowest prio at slot 0, FIFO order among equal prios.
// Latency: push/pop commit in one cycle; pop/evict/drop results are registered and appear the next cycle.
// Backpressure: none; a push into a full array either evicts the worst entry or raises o_drop.
// Build option: ASTRA_PIFO_BYPASS_EN lets a concurrent push that beats the head skip the array.
module astra_pifo_array #(
    parameter int PTW   = 16,
    parameter int MTW   = 32,
    parameter int DEPTH = 16,
    parameter int CNTW  = 5
) (
    input  logic                 i_clk,
    input  logic                 i_arst_n,
    input  logic                 i_push,
    input  logic [MTW+PTW-1:0]   i_push_data,
    input  logic                 i_pop,
    output logic                 o_pop_valid,
    output logic [MTW+PTW-1:0]   o_pop_data,
    output logic                 o_evict_valid,
    output logic [MTW+PTW-1:0]   o_evict_data,
    output logic                 o_drop,
    output logic [CNTW-1:0]      o_count,
    output logic                 o_empty,
    output logic                 o_full
);

    typedef struct packed {
        logic [MTW-1:0] meta;
        logic [PTW-1:0] prio;
    } ent_t;

    localparam logic [CNTW-1:0] LP_DEPTH = CNTW'(DEPTH);

    ent_t            r_ent [DEPTH];
    logic [CNTW-1:0] r_cnt;
    logic            r_pop_vld;
    ent_t            r_pop_dat;
    logic            r_ev_vld;
    ent_t            r_ev_dat;
    logic            r_drop;

    ent_t            w_new;
    logic            w_full;
    logic            w_bypass;
    logic            w_do_pop;
    logic            w_beats_tail;
    logic            w_evict;
    logic            w_drop;
    logic            w_ins;
    ent_t            w_base  [DEPTH];
    ent_t            w_shift [DEPTH];
    ent_t            w_nxt   [DEPTH];
    logic [CNTW-1:0] w_base_cnt;
    logic [CNTW-1:0] w_pos;

    assign w_new        = ent_t'(i_push_data);
    assign w_full       = (r_cnt == LP_DEPTH);
    assign w_beats_tail = (w_new.prio < r_ent[DEPTH-1].prio);

`ifdef ASTRA_PIFO_BYPASS_EN
    // A push that would become the new head (or lands in an empty array) is handed straight back.
    assign w_bypass = i_push && i_pop && ((r_cnt == '0) || (w_new.prio < r_ent[0].prio));
`else
    assign w_bypass = 1'b0;
`endif

    assign w_do_pop = i_pop && (r_cnt != '0) && !w_bypass;
    assign w_evict  = i_push && !i_pop && w_full && w_beats_tail;
    assign w_drop   = i_push && !i_pop && w_full && !w_beats_tail;
    assign w_ins    = i_push && !w_bypass && !w_drop;

    // Array the push is inserted into: post-pop view, or the array minus its tail when evicting.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_base[i] = r_ent[i];
        end
        w_base_cnt = w_full ? (LP_DEPTH - CNTW'(1)) : r_cnt;
        if (w_do_pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                w_base[i] = r_ent[i+1];
            end
            w_base[DEPTH-1] = '0;
            w_base_cnt      = r_cnt - CNTW'(1);
        end
    end

    // Insert position: after every live entry whose prio is <= the new prio (FIFO on ties).
    always_comb begin
        w_pos = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CNTW'(i) < w_base_cnt) && (w_base[i].prio <= w_new.prio)) begin
                w_pos = w_pos + CNTW'(1);
            end
        end
    end

    // Build the post-insert array: entries at and below the insert slot move down by one.
    always_comb begin
        w_shift[0] = w_base[0];
        for (int i = 1; i < DEPTH; i++) begin
            w_shift[i] = w_base[i-1];
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (CNTW'(i) < w_pos) begin
                w_nxt[i] = w_base[i];
            end else if (CNTW'(i) == w_pos) begin
                w_nxt[i] = w_new;
            end else begin
                w_nxt[i] = w_shift[i];
            end
        end
    end

    // Commit array contents, occupancy and the registered pop/evict/drop results.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_ent[i] <= '0;
            end
            r_cnt     <= '0;
            r_pop_vld <= 1'b0;
            r_pop_dat <= '0;
            r_ev_vld  <= 1'b0;
            r_ev_dat  <= '0;
            r_drop    <= 1'b0;
        end else begin
            r_pop_vld <= 1'b0;
            r_ev_vld  <= 1'b0;
            r_drop    <= 1'b0;
            if (w_bypass) begin
                r_pop_vld <= 1'b1;
                r_pop_dat <= w_new;
            end else begin
                if (w_do_pop) begin
                    r_pop_vld <= 1'b1;
                    r_pop_dat <= r_ent[0];
                end
                if (w_ins) begin
                    r_ent <= w_nxt;
                    r_cnt <= w_base_cnt + CNTW'(1);
                end else if (w_do_pop) begin
                    r_ent <= w_base;
                    r_cnt <= w_base_cnt;
                end
                if (w_evict) begin
                    r_ev_vld <= 1'b1;
                    r_ev_dat <= r_ent[DEPTH-1];
                end
                if (w_drop) begin
                    r_drop <= 1'b1;
                end
            end
        end
    end

    assign o_pop_valid   = r_pop_vld;
    assign o_pop_data    = r_pop_dat;
    assign o_evict_valid = r_ev_vld;
    assign o_evict_data  = r_ev_dat;
    assign o_drop        = r_drop;
    assign o_count       = r_cnt;
    assign o_empty       = (r_cnt == '0);
    assign o_full        = (r_cnt == LP_DEPTH);

endmodule

// File: tb/tb_astra_pifo_array.sv
// Purpose: randomized + directed bench for astra_pifo_array against a sorted-queue reference model.
// Latency: expected pop/evict/drop results are queued at issue and consumed when the DUT pulses them.
// Backpressure: not applicable; every operation is issued for exactly one clock.
module tb_astra_pifo_array;

    localparam int PTW   = 8;
    localparam int MTW   = 8;
    localparam int DEPTH = 4;
    localparam int CNTW  = 3;
    localparam int DW    = MTW + PTW;

    typedef logic [DW-1:0] d_t;

    logic            clk = 1'b0;
    logic            arst_n;
    logic            push;
    logic [DW-1:0]   push_data;
    logic            pop;
    logic            pop_valid;
    logic [DW-1:0]   pop_data;
    logic            evict_valid;
    logic [DW-1:0]   evict_data;
    logic            drop;
    logic [CNTW-1:0] count;
    logic            empty;
    logic            full;

    int checks = 0;
    int errors = 0;

    d_t mq[$];
    d_t exp_pop_q[$];
    d_t exp_ev_q[$];
    int exp_drop = 0;

    astra_pifo_array #(.PTW(PTW), .MTW(MTW), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
        .i_clk         (clk),
        .i_arst_n      (arst_n),
        .i_push        (push),
        .i_push_data   (push_data),
        .i_pop         (pop),
        .o_pop_valid   (pop_valid),
        .o_pop_data    (pop_data),
        .o_evict_valid (evict_valid),
        .o_evict_data  (evict_data),
        .o_drop        (drop),
        .o_count       (count),
        .o_empty       (empty),
        .o_full        (full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference insert: place after every element with prio <= new prio.
    task automatic model_ins(input d_t d);
        int k;
        k = mq.size();
        for (int i = 0; i < mq.size(); i++) begin
            if (mq[i][PTW-1:0] > d[PTW-1:0]) begin
                k = i;
                break;
            end
        end
        mq.insert(k, d);
    endtask

    // Issue one operation for one clock and update the model with its expected effects.
    task automatic op(input bit p_push, input bit p_pop, input logic [PTW-1:0] p, input logic [MTW-1:0] m);
        d_t  d;
        bit  done;
        d    = {m, p};
        done = 1'b0;
        push      = p_push;
        pop       = p_pop;
        push_data = d;
        if (p_push && p_pop) begin
`ifdef ASTRA_PIFO_BYPASS_EN
            if (mq.size() == 0 || p < mq[0][PTW-1:0]) begin
                exp_pop_q.push_back(d);
                done = 1'b1;
            end
`endif
            if (!done) begin
                if (mq.size() > 0) exp_pop_q.push_back(mq.pop_front());
                model_ins(d);
            end
        end else if (p_push) begin
            if (mq.size() < DEPTH) begin
                model_ins(d);
            end else if (p < mq[DEPTH-1][PTW-1:0]) begin
                exp_ev_q.push_back(mq.pop_back());
                model_ins(d);
            end else begin
                exp_drop++;
            end
        end else if (p_pop) begin
            if (mq.size() > 0) exp_pop_q.push_back(mq.pop_front());
        end
        @(posedge clk);
        #1;
        push = 1'b0;
        pop  = 1'b0;
        chk("count", 32'(count), 32'(mq.size()));
        chk("empty", 32'(empty), 32'(mq.size() == 0));
        chk("full",  32'(full),  32'(mq.size() == DEPTH));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        while (mq.size() > 0) op(1'b0, 1'b1, '0, '0);
        idle(2);
    endtask

    task automatic chk_pending();
        chk("pop_pending",   32'(exp_pop_q.size()), 32'd0);
        chk("evict_pending", 32'(exp_ev_q.size()),  32'd0);
        chk("drop_pending",  32'(exp_drop),         32'd0);
    endtask

    // Monitor: consume expected results whenever the DUT pulses an output.
    initial begin
        forever begin
            @(negedge clk);
            if (arst_n) begin
                if (pop_valid) begin
                    if (exp_pop_q.size() == 0) chk("pop_unexpected", 32'd1, 32'd0);
                    else chk("pop_data", 32'(pop_data), 32'(exp_pop_q.pop_front()));
                end
                if (evict_valid) begin
                    if (exp_ev_q.size() == 0) chk("evict_unexpected", 32'd1, 32'd0);
                    else chk("evict_data", 32'(evict_data), 32'(exp_ev_q.pop_front()));
                end
                if (drop) begin
                    chk("drop_expected", 32'(exp_drop > 0), 32'd1);
                    if (exp_drop > 0) exp_drop--;
                end
                if (evict_valid || drop) chk("evict_drop_excl", 32'(evict_valid && drop), 32'd0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        arst_n    = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        push_data = '0;
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full",  32'(full),  32'd0);
        chk("rst_outs",  32'({pop_valid, evict_valid, drop}), 32'd0);
        idle(2);
        arst_n = 1'b1;
        idle(1);

        // Sequential ordering
        op(1, 0, 8'd50, 8'h01);
        op(1, 0, 8'd20, 8'h02);
        op(1, 0, 8'd80, 8'h03);
        op(1, 0, 8'd10, 8'h04);
        drain();
        chk("order_empty", 32'(empty), 32'd1);

        // FIFO ties
        op(1, 0, 8'd7, 8'hA0);
        op(1, 0, 8'd7, 8'hB0);
        op(1, 0, 8'd7, 8'hC0);
        drain();

        // Full array: evict then drop
        op(1, 0, 8'd10, 8'h11);
        op(1, 0, 8'd20, 8'h12);
        op(1, 0, 8'd30, 8'h13);
        op(1, 0, 8'd40, 8'h14);
        op(1, 0, 8'd25, 8'h15);
        op(1, 0, 8'd90, 8'h16);
        drain();

        // Concurrent push/pop beating the head
        op(1, 0, 8'd20, 8'h21);
        op(1, 0, 8'd50, 8'h22);
        op(1, 1, 8'd5,  8'h23);
        drain();

        // Concurrent push/pop on a full array
        for (int i = 0; i < DEPTH; i++) op(1, 0, 8'(10 * i + 10), 8'(i));
        op(1, 1, 8'd35, 8'h77);
        drain();

        // Empty-array edges
        op(0, 1, '0, '0);
        chk("lone_pop_vld", 32'(pop_valid), 32'd0);
        op(1, 1, 8'd30, 8'h31);
        drain();
        chk_pending();

        // Randomized traffic with a narrow prio range to provoke ties, evictions and drops
        for (int n = 0; n < 400; n++) begin
            int sel;
            sel = $urandom_range(0, 3);
            op(sel != 1, sel == 1 || sel == 2, 8'($urandom_range(0, 15)), 8'($urandom));
        end
        drain();
        chk_pending();

        // Reset mid-operation with 3 entries held
        op(1, 0, 8'd3, 8'h41);
        op(1, 0, 8'd4, 8'h42);
        op(1, 0, 8'd5, 8'h43);
        idle(2);
        chk_pending();
        push      = 1'b1;
        push_data = {8'h44, 8'd1};
        arst_n    = 1'b0;
        mq.delete();
        #2;
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_outs",  32'({pop_valid, evict_valid, drop}), 32'd0);
        chk("midrst_data",  32'({pop_data, evict_data}), 32'd0);
        chk("midrst_empty", 32'(empty), 32'd1);
        chk("midrst_full",  32'(full),  32'd0);
        idle(1);
        push   = 1'b0;
        arst_n = 1'b1;
        op(0, 1, '0, '0);
        chk("postrst_pop_vld", 32'(pop_valid), 32'd0);
        idle(2);
        chk_pending();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/astra_pifo_array.md
ASTRA_PIFO_ARRAY -- requirements
Module: astra_pifo_array

Interface
REQ-001 SHALL have parameter PTW, default 16, priority field width in bits; a lower value is a higher priority.
REQ-002 SHALL have parameter MTW, default 32, metadata field width in bits.
REQ-003 SHALL have parameter DEPTH, default 16, number of entries; legal range 2..64.
REQ-004 SHALL have parameter CNTW, default 5, occupancy counter width; must satisfy 2^CNTW > DEPTH.
REQ-005 SHALL have port i_clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port i_arst_n, input, 1 bit, asynchronous active-low reset.
REQ-007 SHALL have port i_push, input, 1 bit, push request for one cycle.
REQ-008 SHALL have port i_push_data, input, MTW+PTW bits, {meta, prio}; prio is in bits [PTW-1:0].
REQ-009 SHALL have port i_pop, input, 1 bit, pop request for one cycle.
REQ-010 SHALL have port o_pop_valid, output, 1 bit, one-cycle pulse marking o_pop_data as a fresh pop result.
REQ-011 SHALL have port o_pop_data, output, MTW+PTW bits, last popped element, held until the next valid pop.
REQ-012 SHALL have port o_evict_valid, output, 1 bit, one-cycle pulse marking an eviction of the worst entry.
REQ-013 SHALL have port o_evict_data, output, MTW+PTW bits, the evicted element.
REQ-014 SHALL have port o_drop, output, 1 bit, one-cycle pulse marking a rejected push.
REQ-015 SHALL have ports o_count (CNTW bits, occupancy), o_empty (count==0) and o_full (count==DEPTH), all outputs, all combinational from registered state.

Function
REQ-016 SHALL keep entries sorted in ascending prio order in a register array, with slot 0 as the head.
REQ-017 SHALL break ties FIFO: a pushed element is placed after all existing entries with equal prio.
REQ-018 SHALL complete a push in one cycle: the entry is visible in o_count and at the head on the cycle after i_push.
REQ-019 SHALL, on a pop of a non-empty array, register the head into o_pop_data, pulse o_pop_valid on cycle N+1, and shift the remaining entries up by one.
REQ-020 SHALL ignore a pop of an empty array: o_pop_valid stays 0 and o_pop_data is unchanged.
REQ-021 SHALL, on a push to a full array with no pop, evict slot DEPTH-1 via o_evict_valid/o_evict_data on cycle N+1 if the new prio is strictly lower than that slot's prio, and insert the new element.
REQ-022 SHALL, on a push to a full array with no pop, pulse o_drop on cycle N+1 if the new prio is greater than or equal to the worst prio, leaving the array unchanged.
REQ-023 SHALL, on a simultaneous push and pop with the macro from REQ-030 absent, pop the pre-cycle head and insert the pushed element into the post-pop array; count is unchanged and there is no evict or drop, even when full.
REQ-024 SHALL, on a simultaneous push and pop to an empty array with the macro absent, store the pushed element with count 1 and produce no o_pop_valid.
REQ-025 SHALL keep o_pop_valid, o_evict_valid and o_drop mutually consistent: at most one of evict/drop per cycle, and each is a single-cycle pulse.
REQ-026 SHALL keep o_count in the range 0..DEPTH with no wrap-around.

Reset
REQ-027 SHALL, while i_arst_n is low, immediately clear all entries to invalid, o_count to 0, o_pop_data and o_evict_data to 0, and o_pop_valid, o_evict_valid and o_drop to 0; o_empty reads 1 and o_full reads 0.
REQ-028 SHALL discard any in-flight push or pop when reset asserts mid-operation; the first operation is accepted on the first rising edge after deassertion.

Configuration
REQ-029 SHALL reserve exactly one compile option, the macro ASTRA_PIFO_BYPASS_EN.
REQ-030 SHALL, with ASTRA_PIFO_BYPASS_EN defined, handle a simultaneous push and pop whose prio is strictly lower than the head prio, or that targets an empty array, by returning the pushed element as pop data on cycle N+1 with o_pop_valid=1 and the array and count unchanged; otherwise behave as in REQ-023. Without the macro, REQ-023 and REQ-024 apply unconditionally and no bypass logic is synthesised.

Verification
REQ-031 SHALL cover sequential ordering: push prio 50, 20, 80, 10, then 4 pops -> pop order 10, 20, 50, 80; o_empty=1 afterwards.
REQ-032 SHALL cover FIFO ties: push (7,meta A), (7,B), (7,C), then 3 pops -> meta A, B, C.
REQ-033 SHALL cover a full array with DEPTH=4 holding 10, 20, 30, 40: push 25 -> o_evict_valid with prio 40 and contents 10, 20, 25, 30; then push 90 -> o_drop=1 and contents unchanged.
REQ-034 SHALL cover a concurrent push/pop with contents 20, 50: push 5 plus pop -> without macro: pop 20, contents 5, 50; with ASTRA_PIFO_BYPASS_EN: pop 5, contents 20, 50.
REQ-035 SHALL cover empty-array edges: a lone pop -> o_pop_valid=0; push 30 plus pop -> without macro count=1; with macro pop 30 and count=0.
REQ-036 SHALL cover reset mid-operation: assert i_arst_n=0 in the same cycle as a push with 3 entries held -> o_count=0, all outputs 0; the next pop after release gives o_pop_valid=0.
